// File: rtl/nes_joy_pkg.sv
// Shared definitions for the NES joypad reader: FSM states, button bit
// positions and default protocol timing at the 25 MHz system clock.
package nes_joy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        CLK_HI,
        CLK_LO,
        DONE
    } joy_state_t;

    typedef logic [7:0] buttons_t;

    localparam int NUM_PADS    = 2;
    localparam int NUM_BUTTONS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // 12 us latch, 6 us half serial period, ~60 Hz auto poll at 25 MHz
    localparam int DEF_LATCH_CYCLES = 300;
    localparam int DEF_HALF_CYCLES  = 150;
    localparam int DEF_POLL_PERIOD  = 416667;
    localparam int DEF_CNT_W        = 19;

endpackage

// File: rtl/nes_joy_sync.sv
// Two-flop synchronizer for an asynchronous pad data line. Resets to the
// line's idle-high level so a reset never looks like a pressed button.
module nes_joy_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/nes_joypad_reader.sv
// Polls two NES (4021 shift-register) controllers and presents their
// buttons as active-high bytes, on request or from a free-running timer.
module nes_joypad_reader
    import nes_joy_pkg::*;
#(
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
    parameter int POLL_PERIOD  = DEF_POLL_PERIOD,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       poll_req,
    input  logic       joy_data_1,
    input  logic       joy_data_2,
    output logic       joy_latch,
    output logic       joy_clk_1,
    output logic       joy_clk_2,
    output logic [7:0] joycon_1,
    output logic [7:0] joycon_2,
    output logic       joy_valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LATCH_LAST   = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(HALF_CYCLES - 1);
    localparam bit               AUTO_POLL    = (POLL_PERIOD > 0);
    localparam logic [CNT_W-1:0] TIMER_RELOAD = AUTO_POLL ? CNT_W'(POLL_PERIOD - 1) : '0;

    joy_state_t                   state_reg;
    logic [CNT_W-1:0]             cnt_reg;
    logic [CNT_W-1:0]             timer_reg;
    logic [2:0]                   bit_reg;
    logic                         pending_reg;
    buttons_t [NUM_PADS-1:0]      shift_reg;
    buttons_t [NUM_PADS-1:0]      shift_next;
    logic     [NUM_PADS-1:0]      data_raw;
    logic     [NUM_PADS-1:0]      data_sync;

    logic latch_done;
    logic half_done;
    logic timer_expired;
    logic start_poll;
    logic sample_now;

    assign data_raw = {joy_data_2, joy_data_1};

    generate
        for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            nes_joy_sync u_sync (
                .clk (clk),
                .rst (rst),
                .d   (data_raw[gi]),
                .q   (data_sync[gi])
            );
        end
    endgenerate

    assign latch_done    = (cnt_reg == LATCH_LAST);
    assign half_done     = (cnt_reg == HALF_LAST);
    assign timer_expired = AUTO_POLL && (timer_reg == '0);
    // DONE may start the next poll directly so a queued request costs no idle cycle
    assign start_poll    = ((state_reg == IDLE) || (state_reg == DONE)) &&
                           (poll_req || pending_reg || timer_expired);
    assign sample_now    = ((state_reg == GAP) || (state_reg == CLK_LO)) && half_done;

    // Pads drive 0 for pressed; store the inverted bit so the byte is active-high
    always_comb begin
        shift_next = shift_reg;
        for (int p = 0; p < NUM_PADS; p++) begin
            shift_next[p][bit_reg] = ~data_sync[p];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            timer_reg   <= '0;
            bit_reg     <= '0;
            pending_reg <= 1'b0;
            shift_reg   <= '0;
            joy_latch   <= 1'b0;
            joy_clk_1   <= 1'b0;
            joy_clk_2   <= 1'b0;
            joycon_1    <= '0;
            joycon_2    <= '0;
            joy_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            joy_valid <= 1'b0;

            if (start_poll) begin
                timer_reg   <= TIMER_RELOAD;
                pending_reg <= 1'b0;
            end else begin
                if (timer_reg != '0) begin
                    timer_reg <= timer_reg - 1'b1;
                end
                if (busy && (poll_req || timer_expired)) begin
                    pending_reg <= 1'b1;
                end
            end

            if (sample_now) begin
                shift_reg <= shift_next;
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (start_poll) begin
                        state_reg <= LATCH;
                        cnt_reg   <= '0;
                        bit_reg   <= '0;
                        shift_reg <= '0;
                        joy_latch <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                end

                LATCH: begin
                    if (latch_done) begin
                        state_reg <= GAP;
                        cnt_reg   <= '0;
                        joy_latch <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                // Bit 0 (A) is already on the line after the latch, so it is sampled here
                GAP: begin
                    if (half_done) begin
                        state_reg <= CLK_HI;
                        cnt_reg   <= '0;
                        bit_reg   <= 3'd1;
                        joy_clk_1 <= 1'b1;
                        joy_clk_2 <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                CLK_HI: begin
                    if (half_done) begin
                        state_reg <= CLK_LO;
                        cnt_reg   <= '0;
                        joy_clk_1 <= 1'b0;
                        joy_clk_2 <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                CLK_LO: begin
                    if (half_done) begin
                        cnt_reg <= '0;
                        if (bit_reg == 3'd7) begin
                            // Publish including the bit sampled on this very edge
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            joy_valid <= 1'b1;
                            joycon_1  <= shift_next[0];
                            joycon_2  <= shift_next[1];
                        end else begin
                            state_reg <= CLK_HI;
                            bit_reg   <= bit_reg + 3'd1;
                            joy_clk_1 <= 1'b1;
                            joy_clk_2 <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    joy_latch <= 1'b0;
                    joy_clk_1 <= 1'b0;
                    joy_clk_2 <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_joypad_reader.sv
// Bench for nes_joypad_reader: two pad models, a time-offset model of each
// poll checked every cycle, and directed scenarios with literal expectations.
module tb_nes_joypad_reader;

    localparam int L        = 4;
    localparam int H        = 3;
    localparam int POLL_LEN = L + 15 * H;
    localparam int AUTO_P   = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       poll_req = 1'b0;
    logic       joy_data_1, joy_data_2;
    logic       joy_latch, joy_clk_1, joy_clk_2, joy_valid, busy;
    logic [7:0] joycon_1, joycon_2;

    logic       a_rst = 1'b0;
    logic       a_latch, a_clk_1, a_clk_2, a_valid, a_busy;
    logic [7:0] a_joycon_1, a_joycon_2;

    nes_joypad_reader #(
        .LATCH_CYCLES(L), .HALF_CYCLES(H), .POLL_PERIOD(0), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .poll_req(poll_req),
        .joy_data_1(joy_data_1), .joy_data_2(joy_data_2),
        .joy_latch(joy_latch), .joy_clk_1(joy_clk_1), .joy_clk_2(joy_clk_2),
        .joycon_1(joycon_1), .joycon_2(joycon_2),
        .joy_valid(joy_valid), .busy(busy)
    );

    nes_joypad_reader #(
        .LATCH_CYCLES(L), .HALF_CYCLES(H), .POLL_PERIOD(AUTO_P), .CNT_W(8)
    ) dut_auto (
        .clk(clk), .rst(a_rst), .poll_req(1'b0),
        .joy_data_1(1'b1), .joy_data_2(1'b1),
        .joy_latch(a_latch), .joy_clk_1(a_clk_1), .joy_clk_2(a_clk_2),
        .joycon_1(a_joycon_1), .joycon_2(a_joycon_2),
        .joy_valid(a_valid), .busy(a_busy)
    );

    // Pad models: load on latch, shift towards bit 0 on each joy_clk rise, idle high
    logic [7:0] btn_1 = 8'h00, btn_2 = 8'h00;
    logic       conn_1 = 1'b1, conn_2 = 1'b1;
    logic [7:0] pad_sr_1 = 8'hFF, pad_sr_2 = 8'hFF;
    logic       clk_d_1 = 1'b0, clk_d_2 = 1'b0;

    always @(posedge clk) begin
        if (joy_latch) begin
            pad_sr_1 <= ~btn_1;
            pad_sr_2 <= ~btn_2;
        end else begin
            if (joy_clk_1 && !clk_d_1) pad_sr_1 <= {1'b1, pad_sr_1[7:1]};
            if (joy_clk_2 && !clk_d_2) pad_sr_2 <= {1'b1, pad_sr_2[7:1]};
        end
        clk_d_1 <= joy_clk_1;
        clk_d_2 <= joy_clk_2;
    end

    assign joy_data_1 = conn_1 ? pad_sr_1[0] : 1'b1;
    assign joy_data_2 = conn_2 ? pad_sr_2[0] : 1'b1;

    // Poll model: m_k is the cycle offset since joy_latch rose; outputs follow from it
    bit         m_in = 1'b0, m_pend = 1'b0, m_idle, m_busy, m_expire, m_req;
    int         m_k = 0, m_timer = 0;
    logic [7:0] m_j1 = 8'h00, m_j2 = 8'h00;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_in = 1'b0; m_k = 0; m_pend = 1'b0; m_timer = 0;
            m_j1 = 8'h00; m_j2 = 8'h00;
        end else begin
            m_idle   = !m_in || (m_k == POLL_LEN);
            m_busy   = m_in && (m_k < POLL_LEN);
            m_expire = 1'b0;
            m_req    = poll_req || m_expire;
            if (m_idle && (m_req || m_pend)) begin
                m_in = 1'b1; m_k = 0; m_pend = 1'b0; m_timer = 0;
            end else begin
                if (m_busy && m_req) m_pend = 1'b1;
                if (m_timer > 0) m_timer = m_timer - 1;
                if (m_in) begin
                    m_k = m_k + 1;
                    if (m_k > POLL_LEN) m_in = 1'b0;
                end
            end
            if (m_in && m_k == POLL_LEN) begin
                m_j1 = conn_1 ? btn_1 : 8'h00;
                m_j2 = conn_2 ? btn_2 : 8'h00;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_compare();
        logic e_latch, e_clk, e_busy, e_valid;
        e_latch = m_in && (m_k < L);
        e_clk   = m_in && (m_k >= L + H) && (m_k < POLL_LEN) && (((m_k - L - H) % (2 * H)) < H);
        e_busy  = m_in && (m_k < POLL_LEN);
        e_valid = m_in && (m_k == POLL_LEN);
        checks++;
        if (joy_latch !== e_latch || joy_clk_1 !== e_clk || joy_clk_2 !== e_clk ||
            busy !== e_busy || joy_valid !== e_valid || joycon_1 !== m_j1 ||
            joycon_2 !== m_j2 || (joy_latch && joy_clk_1)) begin
            errors++;
            if (errors <= 20)
                $display("FAIL model cyc=%0d got latch=%b clk=%b%b busy=%b valid=%b j1=%h j2=%h expected latch=%b clk=%b busy=%b valid=%b j1=%h j2=%h",
                         cyc, joy_latch, joy_clk_1, joy_clk_2, busy, joy_valid, joycon_1, joycon_2,
                         e_latch, e_clk, e_busy, e_valid, m_j1, m_j2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_compare();
    endtask

    task automatic pulse_req();
        poll_req = 1'b1;
        tick();
        poll_req = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!joy_valid && n < 300) begin
            tick();
            n++;
        end
        check({name, "_valid_seen"}, joy_valid, 1'b1);
        $display("poll %s: latency %0d joycon_1=%h joycon_2=%h", name, n, joycon_1, joycon_2);
    endtask

    int lat [0:399];
    int ck  [0:399];
    int val [0:399];
    int rises [0:15];
    int falls [0:15];
    int vals  [0:15];

    initial begin
        int n, nr, nf, nv, n_lat, bad_hi, bad_lo, ovl, n_valid, bad_auto;

        rst = 1'b0;
        repeat (3) tick();
        check("reset_latch", joy_latch, 1'b0);
        check("reset_clk", joy_clk_1, 1'b0);
        check("reset_joycon_1", joycon_1, 8'h00);
        check("reset_joycon_2", joycon_2, 8'h00);
        check("reset_valid_busy", {joy_valid, busy}, 2'b00);
        rst = 1'b1;
        repeat (3) tick();

        // 1: A+Start on pad 1, Right on pad 2
        btn_1 = 8'h09; btn_2 = 8'h80;
        pulse_req();
        wait_valid("t1", n);
        check("t1_latency", n, POLL_LEN);
        check("t1_joycon_1", joycon_1, 8'h09);
        check("t1_joycon_2", joycon_2, 8'h80);
        check("t1_busy_on_valid", busy, 1'b0);
        repeat (5) tick();

        // 2: latch and serial clock waveform
        btn_1 = 8'h36; btn_2 = 8'h41;
        pulse_req();
        for (int i = 0; i < 60; i++) begin
            lat[i] = int'(joy_latch); ck[i] = int'(joy_clk_1); val[i] = int'(joy_valid);
            tick();
        end
        n_lat = 0; nr = 0; nf = 0; ovl = 0;
        for (int i = 0; i < 60; i++) begin
            n_lat += lat[i];
            if (lat[i] != 0 && ck[i] != 0) ovl++;
            if (i > 0 && ck[i] == 1 && ck[i-1] == 0 && nr < 16) begin rises[nr] = i; nr++; end
            if (i > 0 && ck[i] == 0 && ck[i-1] == 1 && nf < 16) begin falls[nf] = i; nf++; end
        end
        bad_hi = 0; bad_lo = 0;
        for (int i = 0; i < nr && i < nf; i++) begin
            if (falls[i] - rises[i] != H) bad_hi++;
            if (i + 1 < nr && rises[i+1] - falls[i] != H) bad_lo++;
        end
        check("t2_latch_cycles", n_lat, L);
        check("t2_clk_pulses", nr, 7);
        check("t2_first_clk_offset", (nr > 0) ? rises[0] : -1, L + H);
        check("t2_bad_high_runs", bad_hi, 0);
        check("t2_bad_low_runs", bad_lo, 0);
        check("t2_overlap", ovl, 0);
        check("t2_joycon_1", joycon_1, 8'h36);
        check("t2_joycon_2", joycon_2, 8'h41);

        // 3: two requests mid-poll queue exactly one extra poll
        btn_1 = 8'hA5; btn_2 = 8'h0F;
        pulse_req();
        for (int i = 0; i < 160; i++) begin
            lat[i] = int'(joy_latch); val[i] = int'(joy_valid);
            poll_req = (i == 10 || i == 30);
            tick();
        end
        poll_req = 1'b0;
        nr = 0; nv = 0;
        for (int i = 0; i < 160; i++) begin
            if (lat[i] == 1 && (i == 0 || lat[i-1] == 0) && nr < 16) begin rises[nr] = i; nr++; end
            if (val[i] == 1 && nv < 16) begin vals[nv] = i; nv++; end
        end
        check("t3_poll_count", nr, 2);
        check("t3_valid_count", nv, 2);
        if (nr >= 2 && nv >= 2) begin
            check("t3_restart_gap", rises[1] - vals[0], 1);
            check("t3_second_latency", vals[1] - rises[1], POLL_LEN);
        end
        check("t3_joycon_1", joycon_1, 8'hA5);

        // 4: disconnected pads read zero, then all buttons on pad 1
        conn_1 = 1'b0; conn_2 = 1'b0; btn_1 = 8'h00; btn_2 = 8'h00;
        pulse_req();
        wait_valid("t4a", n);
        check("t4_idle_joycon_1", joycon_1, 8'h00);
        check("t4_idle_joycon_2", joycon_2, 8'h00);
        repeat (3) tick();
        conn_1 = 1'b1; btn_1 = 8'hFF;
        pulse_req();
        wait_valid("t4b", n);
        check("t4_all_joycon_1", joycon_1, 8'hFF);
        check("t4_all_joycon_2", joycon_2, 8'h00);
        repeat (3) tick();

        // 5: reset during the bit-4 clock-high phase
        conn_2 = 1'b1; btn_1 = 8'h5A; btn_2 = 8'hC3;
        pulse_req();
        repeat (26) tick();
        check("t5_in_clk_hi", joy_clk_1, 1'b1);
        rst = 1'b0;
        #1;
        check("t5_rst_latch_clk", {joy_latch, joy_clk_1, joy_clk_2}, 3'b000);
        check("t5_rst_busy_valid", {busy, joy_valid}, 2'b00);
        check("t5_rst_joycon", {joycon_1, joycon_2}, 16'h0000);
        n_valid = 0;
        repeat (4) begin tick(); n_valid += int'(joy_valid); end
        rst = 1'b1;
        repeat (60) begin tick(); n_valid += int'(joy_valid); end
        check("t5_no_valid", n_valid, 0);
        pulse_req();
        wait_valid("t5", n);
        check("t5_latency", n, POLL_LEN);
        check("t5_joycon_1", joycon_1, 8'h5A);
        check("t5_joycon_2", joycon_2, 8'hC3);

        // 6: autonomous polling on the auto-timer instance
        a_rst = 1'b1;
        bad_auto = 0;
        for (int i = 0; i < 360; i++) begin
            lat[i] = int'(a_latch); val[i] = int'(a_valid);
            if (a_clk_1 !== a_clk_2 || (a_latch && a_clk_1)) bad_auto++;
            if (a_valid && a_busy) bad_auto++;
            tick();
        end
        nr = 0; nv = 0;
        for (int i = 1; i < 360; i++) begin
            if (lat[i] == 1 && lat[i-1] == 0 && nr < 16) begin rises[nr] = i; nr++; end
            if (val[i] == 1 && nv < 16) begin vals[nv] = i; nv++; end
        end
        check("t6_poll_count", nr, 4);
        check("t6_valid_count", nv, 4);
        for (int i = 0; i < nr && i < nv; i++) begin
            check("t6_valid_offset", vals[i] - rises[i], POLL_LEN);
            if (i > 0) check("t6_period", rises[i] - rises[i-1], AUTO_P);
        end
        check("t6_waveform_faults", bad_auto, 0);
        check("t6_joycon", {a_joycon_1, a_joycon_2}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
